// File: rtl/alarm_pkg.sv
// Shared types and default constants for the alarm sequencer and its timer.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_e;

  localparam int unsigned SNOOZE_SEC_DEF       = 300;
  localparam int unsigned RING_TIMEOUT_SEC_DEF = 60;
  localparam int unsigned MAX_SNOOZE_DEF       = 3;

  // Alarm fires only on the second boundary of the programmed hour:minute.
  function automatic logic is_alarm_time(
    input logic [7:0] hrs,
    input logic [7:0] min,
    input logic [7:0] sec,
    input logic [7:0] alarm_hrs,
    input logic [7:0] alarm_min
  );
    return (hrs == alarm_hrs) && (min == alarm_min) && (sec == 8'd0);
  endfunction

endpackage

// File: rtl/alarm_sequencer_tick_countdown.sv
// Loadable down-counter stepped by a tick enable; saturates at zero.
// zero_o flags the tick that takes the count from 1 to 0.
module tick_countdown #(
  parameter int unsigned LOAD_VAL = 300,
  parameter int unsigned W        = $clog2(LOAD_VAL + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic load_i,
  input  logic tick_i,
  output logic zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = W'(LOAD_VAL);
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  assign zero_o = tick_i && (count_q == W'(1)) && !clr_i && !load_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm clock sequencer: arm/ring/snooze/stop control with ring timeout,
// limited snoozes per event and a sticky missed-alarm flag.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_SEC       = SNOOZE_SEC_DEF,
  parameter int unsigned RING_TIMEOUT_SEC = RING_TIMEOUT_SEC_DEF,
  parameter int unsigned MAX_SNOOZE       = MAX_SNOOZE_DEF
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic [7:0] hrs,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic [7:0] alarm_hrs,
  input  logic [7:0] alarm_min,
  input  logic       arm,
  input  logic       snooze_key,
  input  logic       stop_key,
  output logic [1:0] state,
  output logic       buzzer,
  output logic       ringing,
  output logic [1:0] snoozes_used,
  output logic       missed
);

  localparam int unsigned RW = $clog2(RING_TIMEOUT_SEC + 1);
  localparam int unsigned UW = $clog2(MAX_SNOOZE + 1);

  alarm_state_e state_q, state_d;
  logic          buzz_q, buzz_d;
  logic [RW-1:0] ring_q, ring_d;
  logic [UW-1:0] used_q, used_d;
  logic          missed_q, missed_d;
  logic          snz_prev_q, stop_prev_q;

  logic          match;
  logic          snz_edge, stop_edge;
  logic [RW-1:0] ring_inc;
  logic          tmr_clr, tmr_load, tmr_tick, tmr_zero;

  assign match     = tick_1hz && is_alarm_time(hrs, min, sec, alarm_hrs, alarm_min);
  assign snz_edge  = snooze_key && !snz_prev_q;
  assign stop_edge = stop_key && !stop_prev_q;
  assign ring_inc  = ring_q + RW'(1);

  tick_countdown #(
    .LOAD_VAL (SNOOZE_SEC)
  ) u_snooze_timer (
    .clk_i  (CLK),
    .rst_ni (reset_n),
    .clr_i  (tmr_clr),
    .load_i (tmr_load),
    .tick_i (tmr_tick),
    .zero_o (tmr_zero)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      buzz_q      <= 1'b0;
      ring_q      <= '0;
      used_q      <= '0;
      missed_q    <= 1'b0;
      // A key held through reset release must not register as a press.
      snz_prev_q  <= 1'b1;
      stop_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      buzz_q      <= buzz_d;
      ring_q      <= ring_d;
      used_q      <= used_d;
      missed_q    <= missed_d;
      snz_prev_q  <= snooze_key;
      stop_prev_q <= stop_key;
    end
  end

  // Priority: disarm, then stop, then an accepted snooze, then tick-driven work.
  // A snooze press that is not accepted falls through as if absent.
  always_comb begin
    state_d  = state_q;
    buzz_d   = buzz_q;
    ring_d   = ring_q;
    used_d   = used_q;
    missed_d = missed_q;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_tick = 1'b0;

    if (!arm) begin
      state_d = IDLE;
      buzz_d  = 1'b0;
      ring_d  = '0;
      used_d  = '0;
      tmr_clr = 1'b1;
    end else if (stop_edge) begin
      state_d  = ARMED;
      missed_d = 1'b0;
      if ((state_q == RINGING) || (state_q == SNOOZE)) begin
        buzz_d  = 1'b0;
        used_d  = '0;
        tmr_clr = 1'b1;
      end
    end else if (snz_edge && (state_q == RINGING) && (used_q < UW'(MAX_SNOOZE))) begin
      state_d  = SNOOZE;
      buzz_d   = 1'b0;
      used_d   = used_q + UW'(1);
      tmr_load = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (match) begin
            state_d = RINGING;
            buzz_d  = 1'b1;
            ring_d  = '0;
            used_d  = '0;
          end
        end
        RINGING: begin
          if (tick_1hz) begin
            ring_d = ring_inc;
            if (ring_inc == RW'(RING_TIMEOUT_SEC)) begin
              state_d  = ARMED;
              buzz_d   = 1'b0;
              missed_d = 1'b1;
            end else begin
              buzz_d = !buzz_q;
            end
          end
        end
        SNOOZE: begin
          tmr_tick = tick_1hz;
          if (tmr_zero) begin
            state_d = RINGING;
            buzz_d  = 1'b1;
            ring_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    state        = state_q;
    ringing      = (state_q == RINGING);
    buzzer       = buzz_q;
    snoozes_used = 2'(used_q);
    missed       = missed_q;
  end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a behavioural model of the alarm rules.
module tb_alarm_sequencer;

  localparam int unsigned SN = 300;
  localparam int unsigned RT = 60;
  localparam int unsigned MS = 3;

  logic       CLK;
  logic       reset_n;
  logic       tick_1hz;
  logic [7:0] hrs, min, sec, alarm_hrs, alarm_min;
  logic       arm, snooze_key, stop_key;
  logic [1:0] state;
  logic       buzzer, ringing, missed;
  logic [1:0] snoozes_used;

  int checks = 0;
  int errors = 0;

  int m_state, m_buzz, m_ring, m_timer, m_used, m_missed, m_pstop, m_psnz;

  alarm_sequencer #(
    .SNOOZE_SEC       (SN),
    .RING_TIMEOUT_SEC (RT),
    .MAX_SNOOZE       (MS)
  ) dut (
    .CLK          (CLK),
    .reset_n      (reset_n),
    .tick_1hz     (tick_1hz),
    .hrs          (hrs),
    .min          (min),
    .sec          (sec),
    .alarm_hrs    (alarm_hrs),
    .alarm_min    (alarm_min),
    .arm          (arm),
    .snooze_key   (snooze_key),
    .stop_key     (stop_key),
    .state        (state),
    .buzzer       (buzzer),
    .ringing      (ringing),
    .snoozes_used (snoozes_used),
    .missed       (missed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_buzz = 0; m_ring = 0; m_timer = 0; m_used = 0; m_missed = 0;
    m_pstop = 1; m_psnz = 1;
  endtask

  // Applies one clock edge of the alarm rules to the model.
  task automatic model_step();
    bit st_e, sn_e, hit;
    st_e = stop_key && (m_pstop == 0);
    sn_e = snooze_key && (m_psnz == 0);
    hit  = tick_1hz && (hrs == alarm_hrs) && (min == alarm_min) && (sec == 0);
    m_pstop = stop_key;
    m_psnz  = snooze_key;
    if (!arm) begin
      m_state = 0; m_buzz = 0; m_ring = 0; m_timer = 0; m_used = 0;
    end else if (st_e) begin
      if (m_state >= 2) begin
        m_buzz = 0; m_used = 0; m_timer = 0;
      end
      m_state  = 1;
      m_missed = 0;
    end else if (sn_e && m_state == 2 && m_used < MS) begin
      m_state = 3; m_timer = SN; m_used++; m_buzz = 0;
    end else begin
      case (m_state)
        0: m_state = 1;
        1: if (hit) begin m_state = 2; m_used = 0; m_ring = 0; m_buzz = 1; end
        2: if (tick_1hz) begin
             m_ring++;
             if (m_ring == RT) begin m_state = 1; m_buzz = 0; m_missed = 1; end
             else m_buzz = 1 - m_buzz;
           end
        default: if (tick_1hz && m_timer > 0) begin
             m_timer--;
             if (m_timer == 0) begin m_state = 2; m_ring = 0; m_buzz = 1; end
           end
      endcase
    end
  endtask

  task automatic compare_all();
    check_val("state", state, m_state);
    check_val("buzzer", buzzer, m_buzz);
    check_val("ringing", ringing, (m_state == 2) ? 1 : 0);
    check_val("snoozes_used", snoozes_used, m_used);
    check_val("missed", missed, m_missed);
  endtask

  task automatic advance_time();
    if (sec == 8'd59) begin
      sec = 8'd0;
      if (min == 8'd59) begin
        min = 8'd0;
        hrs = (hrs == 8'd23) ? 8'd0 : hrs + 8'd1;
      end else min = min + 8'd1;
    end else sec = sec + 8'd1;
  endtask

  task automatic step();
    @(posedge CLK);
    if (!reset_n) model_reset(); else model_step();
    #1;
    compare_all();
    if (tick_1hz) advance_time();
  endtask

  task automatic do_tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    step();
  endtask

  task automatic set_alarm_time();
    hrs = 8'd7; min = 8'd30; sec = 8'd0;
  endtask

  task automatic press_snooze();
    snooze_key = 1'b1; step();
    snooze_key = 1'b0; step();
  endtask

  initial begin
    reset_n = 1'b0; tick_1hz = 1'b0; arm = 1'b0;
    snooze_key = 1'b0; stop_key = 1'b0;
    hrs = 8'd0; min = 8'd0; sec = 8'd0;
    alarm_hrs = 8'd7; alarm_min = 8'd30;
    model_reset();
    #2;
    compare_all();
    check_val("reset_state", state, 0);
    repeat (2) @(negedge CLK);
    reset_n = 1'b1;
    step();
    arm = 1'b1;
    step();
    check_val("armed", state, 1);

    // Ring on match, buzzer toggles each later tick.
    set_alarm_time();
    do_tick();
    check_val("ring_state", state, 2);
    check_val("ring_buzz", buzzer, 1);
    do_tick();
    check_val("toggle_buzz0", buzzer, 0);
    do_tick();
    check_val("toggle_buzz1", buzzer, 1);

    // Ring timeout at 60 ticks, stop clears missed.
    repeat (RT - 3) do_tick();
    check_val("pre_timeout", state, 2);
    do_tick();
    check_val("timeout_state", state, 1);
    check_val("timeout_missed", missed, 1);
    stop_key = 1'b1; step();
    check_val("stop_clr_missed", missed, 0);
    stop_key = 1'b0; step();

    // Three full snoozes, fourth press ignored.
    set_alarm_time();
    do_tick();
    check_val("ring2", state, 2);
    for (int k = 1; k <= MS; k++) begin
      press_snooze();
      check_val("snooze_state", state, 3);
      check_val("snooze_used", snoozes_used, k);
      repeat (SN - 1) do_tick();
      check_val("snooze_pre_end", state, 3);
      do_tick();
      check_val("resume_state", state, 2);
      check_val("resume_used", snoozes_used, k);
    end
    press_snooze();
    check_val("fourth_ignored", state, 2);
    check_val("fourth_used", snoozes_used, MS);

    // Stop and snooze together: stop wins.
    stop_key = 1'b1; snooze_key = 1'b1; step();
    check_val("both_state", state, 1);
    check_val("both_used", snoozes_used, 0);
    stop_key = 1'b0; snooze_key = 1'b0; step();

    // Disarm in the middle of a snooze.
    set_alarm_time();
    do_tick();
    press_snooze();
    repeat (SN - 120) do_tick();
    check_val("mid_snooze", state, 3);
    arm = 1'b0; step();
    check_val("disarm_state", state, 0);
    check_val("disarm_buzz", buzzer, 0);
    arm = 1'b1; step();
    check_val("rearm_state", state, 1);
    repeat (20) do_tick();
    check_val("rearm_no_ring", state, 1);

    // Reset while ringing with stop held.
    set_alarm_time();
    do_tick();
    check_val("ring3", state, 2);
    stop_key = 1'b1;
    #2 reset_n = 1'b0;
    #1 model_reset();
    compare_all();
    step();
    @(negedge CLK);
    reset_n = 1'b1;
    #1;
    check_val("post_reset_state", state, 0);
    check_val("post_reset_buzz", buzzer, 0);
    step();
    check_val("post_reset_armed", state, 1);
    stop_key = 1'b0; step();

    // Randomized traffic.
    for (int i = 0; i < 20000; i++) begin
      tick_1hz = ($urandom_range(0, 2) == 0);
      if (tick_1hz && $urandom_range(0, 199) == 0) set_alarm_time();
      if ($urandom_range(0, 19) == 0) snooze_key = ~snooze_key;
      if ($urandom_range(0, 299) == 0) stop_key = ~stop_key;
      if ($urandom_range(0, 999) == 0) arm = 1'b0;
      else if (!arm && $urandom_range(0, 29) == 0) arm = 1'b1;
      if ($urandom_range(0, 4999) == 0) begin
        reset_n = 1'b0;
        #1 model_reset();
        step();
        reset_n = 1'b1;
      end else begin
        step();
      end
    end
    tick_1hz = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
